// File: rtl/uart_rxbuf_if.sv
// CPU-side bus of the buffered UART receiver: chip select, register select,
// read/write strobe, data in/out and the receive-available flag.
interface uart_rxbuf_if;
  logic       cs;
  logic       a0;
  logic       rnw;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rx_avail;

  modport master (output cs, a0, rnw, din, input dout, rx_avail);
  modport slave  (input cs, a0, rnw, din, output dout, rx_avail);
endinterface

// File: rtl/uart_rxbuf.sv
// 8N1 serial receiver feeding a small byte FIFO, with data and status/control
// registers on the CPU bus.
module uart_rxbuf #(
  parameter int BIT_CYCLES = 217,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rxd,
  uart_rxbuf_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(BIT_CYCLES);
  localparam int NW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYCLES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic          rxm, rxs;
  logic [2:0]    state;
  logic [CW-1:0] bitcnt;
  logic [2:0]    n;
  logic [7:0]    sr;
  logic          push, ferr_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxm <= 1'b1;
      rxs <= 1'b1;
    end else begin
      rxm <= rxd;
      rxs <= rxm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      n      <= '0;
      sr     <= '0;
    end else begin
      case (state)
        IDLE: if (!rxs) begin
          state  <= START;
          bitcnt <= HALF_M1;
        end
        START: if (bitcnt == '0) begin
          if (!rxs) begin
            state  <= DATA;
            bitcnt <= FULL_M1;
            n      <= '0;
          end else begin
            state <= IDLE;
          end
        end else bitcnt <= bitcnt - CW'(1);
        DATA: if (bitcnt == '0) begin
          sr     <= {rxs, sr[7:1]};
          bitcnt <= FULL_M1;
          if (n == 3'd7) state <= STOP;
          else n <= n + 3'd1;
        end else bitcnt <= bitcnt - CW'(1);
        // Leaving at mid-stop-bit leaves half a bit of margin for the next start edge.
        STOP: if (bitcnt == '0) state <= rxs ? IDLE : WAIT_HIGH;
              else bitcnt <= bitcnt - CW'(1);
        WAIT_HIGH: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign push     = (state == STOP) && (bitcnt == '0) &&  rxs;
  assign ferr_set = (state == STOP) && (bitcnt == '0) && !rxs;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rptr, wptr;
  logic [NW-1:0]         count, count_nxt;
  logic                  ovr, ferr, rd_q;
  logic                  full, empty, rd_stb, pop, wr, flush;

  assign full   = (count == NW'(DEPTH));
  assign empty  = (count == '0);
  assign rd_stb = bus.cs & bus.rnw & ~bus.a0;
  assign pop    = rd_stb & ~rd_q & ~empty;
  assign flush  = bus.cs & ~bus.rnw & bus.a0 & bus.din[0];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr     = push & (~full | pop);

  always_comb begin
    count_nxt = count;
    if (wr && !pop)      count_nxt = count + NW'(1);
    else if (pop && !wr) count_nxt = count - NW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr         <= '0;
      wptr         <= '0;
      count        <= '0;
      ovr          <= 1'b0;
      ferr         <= 1'b0;
      rd_q         <= 1'b0;
      bus.rx_avail <= 1'b0;
    end else begin
      rd_q <= rd_stb;
      if (flush) begin
        rptr         <= '0;
        wptr         <= '0;
        count        <= '0;
        ovr          <= 1'b0;
        ferr         <= 1'b0;
        bus.rx_avail <= 1'b0;
      end else begin
        if (wr)  wptr <= wptr + DEPTH_LOG2'(1);
        if (pop) rptr <= rptr + DEPTH_LOG2'(1);
        count        <= count_nxt;
        bus.rx_avail <= (count_nxt != '0);
        if (push && full && !pop) ovr  <= 1'b1;
        if (ferr_set)             ferr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wptr] <= sr;
  end

  always_comb begin
    bus.dout = 8'h00;
    if (bus.cs && bus.rnw) begin
      if (bus.a0) bus.dout = {4'b0, ferr, ovr, full, ~empty};
      else if (!empty) bus.dout = mem[rptr];
    end
  end
endmodule

// File: tb/tb_uart_rxbuf.sv
// Randomized scoreboard bench for uart_rxbuf against a queue-based model of
// the receive FIFO and status flags.
module tb_uart_rxbuf;
  localparam int B       = 16;
  localparam int H       = B / 2;
  localparam int PUSH_I  = 2 + H + 9 * B;

  logic clk = 1'b0;
  logic reset;
  logic rxd;
  uart_rxbuf_if bus ();

  uart_rxbuf #(.BIT_CYCLES(B), .DEPTH_LOG2(3)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] val; bit st; } exp_t;
  exp_t       exp_q [$];
  logic [7:0] model_q [$];
  bit         m_ovr, m_ferr;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] status();
    return {4'b0, m_ferr, m_ovr, model_q.size() == 8, model_q.size() != 0};
  endfunction

  // Monitor: the first cycle of every read strobe is a DUT response.
  bit rd_prev = 0;
  always @(negedge clk) begin
    if (reset) rd_prev = 0;
    else begin
      if (bus.cs && bus.rnw && !rd_prev) begin
        if (exp_q.size() == 0) check("unexpected_read", bus.dout, 8'hxx);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.st ? "status" : "data", bus.dout, e.val);
        end
      end
      rd_prev = bus.cs && bus.rnw;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    model_q.delete();
    m_ovr  = 0;
    m_ferr = 0;
  endtask

  task automatic bus_read(input bit a0v);
    exp_t e;
    int   hold;
    check("rx_avail", {7'b0, bus.rx_avail}, {7'b0, model_q.size() != 0});
    e.st  = a0v;
    e.val = a0v ? status() : (model_q.size() != 0 ? model_q.pop_front() : 8'h00);
    exp_q.push_back(e);
    bus.cs = 1; bus.rnw = 1; bus.a0 = a0v;
    hold = $urandom_range(1, 3);
    repeat (hold) tick();
    bus.cs = 0;
    tick();
  endtask

  task automatic bus_write(input bit a0v, input logic [7:0] d);
    bus.cs = 1; bus.rnw = 0; bus.a0 = a0v; bus.din = d;
    tick();
    bus.cs = 0; bus.rnw = 1;
    tick();
    if (a0v && d[0]) model_clear();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit rd_at_push);
    logic [9:0] fr;
    exp_t       e;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10 * B; i++) begin
      tick();
      rxd = fr[i / B];
      if (rd_at_push && i == PUSH_I) begin
        e.st  = 0;
        e.val = model_q.pop_front();
        exp_q.push_back(e);
        bus.cs = 1; bus.rnw = 1; bus.a0 = 0;
      end
      if (rd_at_push && i == PUSH_I + 2) bus.cs = 0;
    end
    if (stop_ok) begin
      if (model_q.size() < 8) model_q.push_back(b);
      else m_ovr = 1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; rxd = 1;
    bus.cs = 0; bus.rnw = 1; bus.a0 = 0; bus.din = 8'h00;
    model_clear();
    repeat (3) tick();
    reset = 0;
    tick();
    check("reset_rx_avail", {7'b0, bus.rx_avail}, 8'h00);
    check("reset_dout_idle", bus.dout, 8'h00);
    bus_read(1);
    bus_read(0);

    // single byte
    send_byte(8'hA5, 1, 0);
    repeat (2) tick();
    bus_read(1);
    bus_read(0);
    bus_read(1);

    // fill and overrun, then register-write decoding
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1, 0);
    bus_read(1);
    for (int i = 0; i < 8; i++) bus_read(0);
    bus_read(1);
    bus_write(0, 8'hFF);
    bus_write(1, 8'hFE);
    bus_read(1);
    bus_write(1, 8'h01);
    bus_read(1);

    // framing error with a 3-bit-time low, then a good byte
    send_byte(8'h3C, 0, 0);
    repeat (2 * B) tick();
    m_ferr = 1;
    rxd = 1;
    repeat (B) tick();
    send_byte(8'h55, 1, 0);
    bus_read(1);
    bus_write(1, 8'h01);
    bus_read(1);
    bus_read(0);

    // glitch shorter than half a bit, then a normal frame must still decode
    rxd = 0;
    repeat (B / 4) tick();
    rxd = 1;
    repeat (2 * B) tick();
    bus_read(1);
    send_byte(8'hC3, 1, 0);
    bus_read(0);

    // full FIFO: read starts on the exact push cycle
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1, 0);
    bus_read(1);
    send_byte(8'h7E, 1, 1);
    bus_read(1);
    for (int i = 0; i < 8; i++) bus_read(0);
    bus_read(1);

    // back-to-back frames with one stop bit
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1, 0);
    for (int i = 0; i < 6; i++) bus_read(0);

    // random mix of frames, reads and flushes
    repeat (30) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          send_byte(8'($urandom), 1, 0);
          repeat ($urandom_range(0, B)) tick();
        end
        2: bus_read(0);
        3: bus_read(1);
        default: if ($urandom_range(0, 3) == 0) bus_write(1, 8'h01);
                 else bus_read(0);
      endcase
    end
    bus_write(1, 8'h01);

    // reset mid-frame aborts without push or flags
    send_byte(8'h11, 1, 0);
    rxd = 0;
    repeat (4 * B) tick();
    reset = 1; rxd = 1;
    repeat (2) tick();
    reset = 0;
    model_clear();
    repeat (2 * B) tick();
    bus_read(1);
    bus_read(0);

    repeat (3) tick();
    check("scoreboard_drain", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
